// File: rtl/bp_fe_bp_update_sched.sv
`default_nettype none
// ============================================================================
// Module   : bp_fe_bp_update_sched
// Brief    : In-order FIFO of branch-resolution updates feeding the single
//            predictor write port, with read-collision deferral and a bound.
// Revision : 1.0
// ============================================================================
module bp_fe_bp_update_sched #(
  parameter int bht_idx_width_p = 9,
  parameter int fifo_els_p      = 4,
  parameter int stall_limit_p   = 3
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               upd_v_i,
  input  logic [bht_idx_width_p-1:0]         upd_idx_i,
  input  logic                               upd_correct_i,
  output logic                               upd_ready_o,
  input  logic                               flush_i,
  input  logic                               r_v_i,
  input  logic [bht_idx_width_p-1:0]         idx_r_i,
  output logic                               w_v_o,
  output logic [bht_idx_width_p-1:0]         idx_w_o,
  output logic                               correct_o,
  output logic                               empty_o,
  output logic [$clog2(fifo_els_p+1)-1:0]    count_o
);

  localparam int PTR_W   = $clog2(fifo_els_p);
  localparam int CNT_W   = $clog2(fifo_els_p+1);
  localparam int STALL_W = $clog2(stall_limit_p+1);
  localparam logic [CNT_W-1:0]   C_FIFO_ELS    = CNT_W'(fifo_els_p);
  localparam logic [CNT_W-1:0]   C_CNT_ONE     = CNT_W'(1);
  localparam logic [STALL_W-1:0] C_STALL_LIMIT = STALL_W'(stall_limit_p);
  localparam logic [STALL_W-1:0] C_STALL_ONE   = STALL_W'(1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e                      r_state, w_state_n;
  logic [bht_idx_width_p-1:0]  r_idx_mem     [fifo_els_p];
  logic                        r_correct_mem [fifo_els_p];
  logic [PTR_W-1:0]            r_rptr, r_wptr;
  logic [CNT_W-1:0]            r_count;
  logic                        r_empty;
  logic [STALL_W-1:0]          r_stall_cnt, w_stall_cnt_n;
  logic                        w_full, w_enq, w_deq, w_conflict, w_remain;
  logic [bht_idx_width_p-1:0]  w_head_idx;
  logic                        w_head_correct;
  logic [CNT_W-1:0]            w_count_n;

  assign w_full         = (r_count == C_FIFO_ELS);
  assign upd_ready_o    = ~w_full & ~flush_i & ~reset_i;
  assign w_enq          = upd_v_i & upd_ready_o;
  assign w_head_idx     = r_idx_mem[r_rptr];
  assign w_head_correct = r_correct_mem[r_rptr];
  assign w_conflict     = r_v_i & (idx_r_i == w_head_idx);
  // Entries still queued after the head leaves, counting this cycle's enqueue.
  assign w_remain       = (r_count != C_CNT_ONE) | w_enq;
  assign w_deq          = w_v_o;
  assign w_count_n      = r_count + CNT_W'(w_enq) - CNT_W'(w_deq);

  assign idx_w_o   = w_v_o ? w_head_idx : '0;
  assign correct_o = w_v_o ? w_head_correct : 1'b0;
  assign empty_o   = r_empty;
  assign count_o   = r_count;

  always_comb begin
    w_v_o         = 1'b0;
    w_state_n     = r_state;
    w_stall_cnt_n = r_stall_cnt;
    case (r_state)
      S_ISSUE: w_v_o = ~w_conflict & ~flush_i;
      S_HOLD:  w_v_o = (~w_conflict | (r_stall_cnt == C_STALL_LIMIT)) & ~flush_i;
      default: w_v_o = 1'b0;
    endcase

    if (flush_i) begin
      w_state_n     = S_EMPTY;
      w_stall_cnt_n = '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_enq) w_state_n = S_ISSUE;
        end
        S_ISSUE: begin
          if (w_v_o) begin
            w_state_n = w_remain ? S_ISSUE : S_EMPTY;
          end else begin
            w_state_n     = S_HOLD;
            w_stall_cnt_n = C_STALL_ONE;
          end
        end
        S_HOLD: begin
          if (w_v_o) begin
            w_state_n     = w_remain ? S_ISSUE : S_EMPTY;
            w_stall_cnt_n = '0;
          end else begin
            w_stall_cnt_n = r_stall_cnt + C_STALL_ONE;
          end
        end
        default: begin
          w_state_n     = S_EMPTY;
          w_stall_cnt_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= S_EMPTY;
      r_stall_cnt <= '0;
      r_rptr      <= '0;
      r_wptr      <= '0;
      r_count     <= '0;
      r_empty     <= 1'b1;
    end else begin
      r_state     <= w_state_n;
      r_stall_cnt <= w_stall_cnt_n;
      if (flush_i) begin
        r_rptr  <= '0;
        r_wptr  <= '0;
        r_count <= '0;
        r_empty <= 1'b1;
      end else begin
        if (w_enq) r_wptr <= r_wptr + PTR_W'(1);
        if (w_deq) r_rptr <= r_rptr + PTR_W'(1);
        r_count <= w_count_n;
        r_empty <= (w_count_n == '0);
      end
    end
  end

  // Payload storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_idx_mem[r_wptr]     <= upd_idx_i;
      r_correct_mem[r_wptr] <= upd_correct_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bp_fe_bp_update_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_fe_bp_update_sched
// Brief    : Vector table with per-cycle expectations and a write scoreboard.
// Revision : 1.0
// ============================================================================
module tb_bp_fe_bp_update_sched;

  localparam int IW = 9;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          upd_v_i = 1'b0;
  logic [IW-1:0] upd_idx_i = '0;
  logic          upd_correct_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          r_v_i = 1'b0;
  logic [IW-1:0] idx_r_i = '0;
  logic          upd_ready_o, w_v_o, correct_o, empty_o;
  logic [IW-1:0] idx_w_o;
  logic [2:0]    count_o;

  bp_fe_bp_update_sched #(
    .bht_idx_width_p (IW),
    .fifo_els_p      (4),
    .stall_limit_p   (3)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .upd_v_i       (upd_v_i),
    .upd_idx_i     (upd_idx_i),
    .upd_correct_i (upd_correct_i),
    .upd_ready_o   (upd_ready_o),
    .flush_i       (flush_i),
    .r_v_i         (r_v_i),
    .idx_r_i       (idx_r_i),
    .w_v_o         (w_v_o),
    .idx_w_o       (idx_w_o),
    .correct_o     (correct_o),
    .empty_o       (empty_o),
    .count_o       (count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          uv;
    logic [IW-1:0] idx;
    logic          c;
    logic          rv;
    logic [IW-1:0] ir;
    logic          fl;
    logic          ewv;
    logic          erdy;
    int            ecnt;
  } vec_t;

  vec_t          tbl[$];
  logic [IW:0]   sb[$];
  int            nerr = 0;
  int            nchk = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t v(input logic uv, input int idx, input logic c,
                             input logic rv, input int ir, input logic fl,
                             input logic ewv, input logic erdy, input int ecnt);
    vec_t t;
    t.uv = uv; t.idx = IW'(idx); t.c = c; t.rv = rv; t.ir = IW'(ir); t.fl = fl;
    t.ewv = ewv; t.erdy = erdy; t.ecnt = ecnt;
    return t;
  endfunction

  // Drive at the falling edge, check just before the next rising edge.
  task automatic step(input vec_t t, input string tag);
    logic [IW:0] e;
    @(negedge clk_i);
    upd_v_i = t.uv; upd_idx_i = t.idx; upd_correct_i = t.c;
    r_v_i = t.rv; idx_r_i = t.ir; flush_i = t.fl;
    #4;
    chk({tag, " w_v"}, 32'(w_v_o), 32'(t.ewv));
    chk({tag, " ready"}, 32'(upd_ready_o), 32'(t.erdy));
    chk({tag, " count"}, 32'(count_o), 32'(t.ecnt));
    chk({tag, " empty"}, 32'(empty_o), 32'(t.ecnt == 0));
    if (w_v_o) begin
      if (sb.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL %s write: got idx 0x%0h with no update outstanding", tag, idx_w_o);
      end else begin
        e = sb.pop_front();
        chk({tag, " wdata"}, 32'({idx_w_o, correct_o}), 32'(e));
      end
    end else begin
      chk({tag, " idle wdata"}, 32'({idx_w_o, correct_o}), 32'(0));
    end
    if (t.fl) sb.delete();
    else if (t.uv && t.erdy) sb.push_back({t.idx, t.c});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // uv idx c | rv ir fl | w_v rdy cnt
    tbl.push_back(v(1,'h05,1, 0,0,0, 0,1,0));   // single update
    tbl.push_back(v(0,0,0,    0,0,0, 1,1,1));
    tbl.push_back(v(0,0,0,    0,0,0, 0,1,0));
    tbl.push_back(v(1,'hA0,0, 0,0,0, 0,1,0));   // four back-to-back
    tbl.push_back(v(1,'hA1,1, 0,0,0, 1,1,1));
    tbl.push_back(v(1,'hA2,0, 0,0,0, 1,1,1));
    tbl.push_back(v(1,'hA3,1, 0,0,0, 1,1,1));
    tbl.push_back(v(0,0,0,    0,0,0, 1,1,1));
    tbl.push_back(v(0,0,0,    0,0,0, 0,1,0));
    tbl.push_back(v(1,'h30,1, 0,0,0,     0,1,0)); // fill under conflict
    tbl.push_back(v(1,'h31,0, 1,'h30,0,  0,1,1));
    tbl.push_back(v(1,'h32,1, 1,'h30,0,  0,1,2));
    tbl.push_back(v(1,'h33,0, 1,'h30,0,  0,1,3));
    tbl.push_back(v(1,'h34,1, 1,'h30,0,  1,0,4)); // full: 5th refused, limit hit
    tbl.push_back(v(0,0,0,    0,0,0,     1,1,3));
    tbl.push_back(v(0,0,0,    0,0,0,     1,1,2));
    tbl.push_back(v(0,0,0,    0,0,0,     1,1,1));
    tbl.push_back(v(0,0,0,    0,0,0,     0,1,0));
    tbl.push_back(v(1,'h10,1, 0,0,0,     0,1,0)); // conflict then clear
    tbl.push_back(v(0,0,0,    1,'h10,0,  0,1,1));
    tbl.push_back(v(0,0,0,    1,'h10,0,  0,1,1));
    tbl.push_back(v(0,0,0,    1,'h11,0,  1,1,1));
    tbl.push_back(v(0,0,0,    0,0,0,     0,1,0));
    tbl.push_back(v(1,'h20,0, 0,0,0,     0,1,0)); // starvation limit, twice
    tbl.push_back(v(1,'h21,1, 1,'h20,0,  0,1,1));
    tbl.push_back(v(0,0,0,    1,'h20,0,  0,1,2));
    tbl.push_back(v(0,0,0,    1,'h20,0,  0,1,2));
    tbl.push_back(v(0,0,0,    1,'h20,0,  1,1,2));
    tbl.push_back(v(0,0,0,    1,'h21,0,  0,1,1));
    tbl.push_back(v(0,0,0,    1,'h21,0,  0,1,1));
    tbl.push_back(v(0,0,0,    1,'h21,0,  0,1,1));
    tbl.push_back(v(0,0,0,    1,'h21,0,  1,1,1));
    tbl.push_back(v(0,0,0,    0,0,0,     0,1,0));
    tbl.push_back(v(1,'h40,1, 0,0,0,     0,1,0)); // flush with traffic
    tbl.push_back(v(1,'h41,0, 1,'h40,0,  0,1,1));
    tbl.push_back(v(1,'h42,1, 1,'h40,0,  0,1,2));
    tbl.push_back(v(1,'h43,1, 0,0,1,     0,0,3));
    tbl.push_back(v(0,0,0,    0,0,0,     0,1,0));
    tbl.push_back(v(0,0,0,    0,0,0,     0,1,0));

    #12;
    chk("rst ready", 32'(upd_ready_o), 32'(0));
    chk("rst w_v", 32'(w_v_o), 32'(0));
    chk("rst wdata", 32'({idx_w_o, correct_o}), 32'(0));
    chk("rst empty", 32'(empty_o), 32'(1));
    chk("rst count", 32'(count_o), 32'(0));
    @(negedge clk_i);
    reset_i = 1'b0;
    #1;
    chk("post-rst ready", 32'(upd_ready_o), 32'(1));

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], $sformatf("v%0d", i));

    // Asynchronous reset between edges with two entries queued.
    step(v(1,'h50,1, 0,0,0,     0,1,0), "ar0");
    step(v(1,'h51,0, 1,'h50,0,  0,1,1), "ar1");
    step(v(0,0,0,    1,'h50,0,  0,1,2), "ar2");
    @(negedge clk_i);
    r_v_i = 1'b0;
    #1;
    chk("ar pre w_v", 32'(w_v_o), 32'(1));
    #1;
    reset_i = 1'b1;
    #1;
    chk("ar w_v", 32'(w_v_o), 32'(0));
    chk("ar count", 32'(count_o), 32'(0));
    chk("ar empty", 32'(empty_o), 32'(1));
    chk("ar ready", 32'(upd_ready_o), 32'(0));
    sb.delete();
    @(negedge clk_i);
    reset_i = 1'b0;
    for (int i = 0; i < 4; i++)
      step(v(0,0,0, 0,0,0, 0,1,0), $sformatf("ar_idle%0d", i));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bp_fe_bp_update_sched.md
# bp_fe_bp_update_sched

Update scheduler for the front-end tournament branch predictor. Buffers branch-resolution updates from the backend in a small in-order FIFO and issues them one per cycle to the predictor's single write port. Defers an update whose index collides with a same-cycle predictor read, and bounds that deferral with a starvation limit. Sits between the backend resolution interface and the predictor's `w_v_i`/`idx_w_i`/`correct_i` inputs. Strict in-order issue is mandatory because the predictor's global history shifts on every write.

## Interface
- `bht_idx_width_p`, 9: predictor index width.
- `fifo_els_p`, 4: FIFO depth; power of 2, at least 2.
- `stall_limit_p`, 3: maximum consecutive cycles the head may be deferred by read collisions; at least 1.
- `clk_i` in 1: single clock, posedge.
- `reset_i` in 1: asynchronous, active-high reset.
- `upd_v_i` in 1: update request valid.
- `upd_idx_i` in `bht_idx_width_p`: index of the resolved branch.
- `upd_correct_i` in 1: the prediction was correct.
- `upd_ready_o` out 1: the scheduler accepts an update this cycle.
- `flush_i` in 1: discard all queued updates.
- `r_v_i` in 1: predictor read valid (snooped).
- `idx_r_i` in `bht_idx_width_p`: predictor read index (snooped).
- `w_v_o` out 1: write valid to the predictor.
- `idx_w_o` out `bht_idx_width_p`: write index.
- `correct_o` out 1: write correctness bit.
- `empty_o` out 1: FIFO empty.
- `count_o` out `$clog2(fifo_els_p+1)`: number of occupied entries.

## Operation
- **FIFO storage:** circular buffer holding {idx, correct}. Read and write pointers are `$clog2(fifo_els_p)` bits and wrap modulo `fifo_els_p`. Occupancy counter ranges 0..`fifo_els_p`.
- **Enqueue:** occurs when `upd_v_i & upd_ready_o`.
  - `upd_ready_o = ~full & ~flush_i`.
  - When full, there is no enqueue even if a dequeue happens in the same cycle.
- **No bypass:** an entry enqueued in cycle N can issue in cycle N+1 at the earliest.
- **Conflict:** `conflict = r_v_i & (idx_r_i == head.idx)`.
- **States:** EMPTY, ISSUE, HOLD; `stall_cnt` is `$clog2(stall_limit_p+1)` bits.
  - **EMPTY:**
    - Outputs: `w_v_o=0`.
    - Transition: go to ISSUE when count becomes nonzero.
  - **ISSUE:**
    - Outputs: `w_v_o = ~conflict & ~flush_i`.
    - If the head issues: dequeue it. Stay in ISSUE if entries remain, otherwise go to EMPTY.
    - If a conflict occurs: `stall_cnt <= 1`, go to HOLD.
  - **HOLD:**
    - Outputs: `w_v_o = (~conflict | stall_cnt == stall_limit_p) & ~flush_i`.
    - If the head issues: `stall_cnt <= 0`. Go to ISSUE if entries remain, otherwise go to EMPTY.
    - Otherwise: `stall_cnt <= stall_cnt + 1`.
    - The counter never exceeds `stall_limit_p`.
- **Write port drive:**
  - `idx_w_o`/`correct_o` equal the head entry when `w_v_o=1`, and are 0 otherwise.
  - `w_v_o` depends combinationally on `r_v_i`/`idx_r_i`/`flush_i` and the current state. It has no combinational path from `upd_*`.
- **Flush:**
  - In the flush cycle: `w_v_o=0`, no enqueue.
  - At the next edge: pointers, count, and `stall_cnt` clear, and state goes to EMPTY.
- **Simultaneous enqueue and dequeue (not full):** count is unchanged and both pointers advance.
- **Status:** `empty_o = (count==0)`; `count_o` = count. Both are registered state.

## Timing
- **Reset:** asynchronous assert clears all state immediately.
  - During reset: `upd_ready_o=0`, `w_v_o=0`, `idx_w_o=0`, `correct_o=0`, `empty_o=1`, `count_o=0`, state EMPTY.
  - First cycle after deassert: `upd_ready_o=1`.
- **Mid-operation reset:** queued updates are lost and no write is issued.
- **Latency:** minimum 1 cycle from accepted update to `w_v_o`.
- **Throughput:** 1 update per cycle sustained, in the absence of conflicts.
- **Maximum deferral:** `stall_limit_p` cycles. The head issues on cycle `stall_limit_p+1` after its first conflict regardless of `r_v_i`.
- **Ordering:** issue order exactly equals acceptance order. The head is never skipped.

## Test plan
- **Reset and single update:** reset, then an update idx=0x05 correct=1 in cycle 1. Required: `w_v_o=1`, idx=0x05, correct=1 in cycle 2; `count_o` returns 1 then 0; `empty_o`=1 in cycle 3.
- **Full and back-to-back:**
  - Enqueue 4 updates back-to-back with `r_v_i=0`: issued in order, one per cycle, starting one cycle after the first.
  - Enqueue 5 updates while the write side is held by conflicts: `upd_ready_o=0` when `count_o=4`, and the 5th update is not accepted.
- **Conflict then clear:** head idx=0x10, `r_v_i=1` with `idx_r_i=0x10` for 2 cycles, then `idx_r_i=0x11`. Required: `w_v_o=0` for 2 cycles, then 1 with idx=0x10.
- **Starvation limit:** head idx=0x20 with a continuous matching read. Required: `w_v_o=0` for 3 cycles, `w_v_o=1` in the 4th (`stall_limit_p=3`); the next head starts with `stall_cnt=0`.
- **Flush with traffic:** 3 entries queued and `upd_v_i=1` asserted in the flush cycle. Required: no write in that cycle, `count_o=0` and `empty_o=1` next cycle, and the new update is not recorded.
- **Asynchronous reset mid-stream:** assert `reset_i` between edges with 2 entries queued. Required: `w_v_o=0` and `count_o=0` immediately, and no write after deassert.
